// File: rtl/ucstats_invl_sched.sv
// Interval scheduler: one uC stats request per tick, then grants enabled link engines in ascending order.
// Optional per-link grant timeout is built when UCSTATS_SCHED_TIMEOUT_EN is defined.
module ucstats_invl_sched #(
  parameter int LINKS       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iINTERVAL_TICK,
  input  logic [LINKS-1:0] iLINK_EN,
  output logic             oUCSTATS_REQ,
  input  logic             iUCSTATS_GNT,
  output logic             oUCSTATS_DONE,
  output logic [LINKS-1:0] oLE_GNT,
  input  logic [LINKS-1:0] iLE_RD_DONE,
  output logic [3:0]       oCUR_LINK,
  output logic             oBUSY,
  output logic [15:0]      oOVERRUN_CNT,
  output logic [LINKS-1:0] oTIMEOUT_LINKS
);
  typedef enum logic [2:0] {IDLE, REQ, GNT, NEXT, DONE} state_t;

  state_t           state, state_nxt;
  logic [LINKS-1:0] en_lat;
  logic [4:0]       base;
  logic [3:0]       sel;
  logic [LINKS-1:0] sel_oh;
  logic             found;
  logic             rd_done;
  logic             tmo_hit;

  // Lowest enabled link at or above base: from 0 when leaving REQ, above the current link otherwise.
  always_comb begin
    base   = (state == REQ) ? 5'd0 : ({1'b0, oCUR_LINK} + 5'd1);
    sel    = '0;
    sel_oh = '0;
    found  = 1'b0;
    for (int j = LINKS - 1; j >= 0; j--) begin
      if (en_lat[j] && (5'(j) >= base)) begin
        sel    = 4'(j);
        sel_oh = '0;
        sel_oh[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // Only the granted link's done counts; others are masked off by the one-hot grant.
  assign rd_done = |(iLE_RD_DONE & oLE_GNT);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (iINTERVAL_TICK && |iLINK_EN) state_nxt = REQ;
      REQ:     if (iUCSTATS_GNT) state_nxt = GNT;
      GNT:     if (rd_done || tmo_hit) state_nxt = NEXT;
      NEXT:    state_nxt = found ? GNT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state        <= IDLE;
      en_lat       <= '0;
      oLE_GNT      <= '0;
      oCUR_LINK    <= '0;
      oOVERRUN_CNT <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == REQ) en_lat <= iLINK_EN;
      if (state_nxt == GNT && state != GNT) begin
        oLE_GNT   <= sel_oh;
        oCUR_LINK <= sel;
      end else if (state_nxt != GNT) begin
        oLE_GNT <= '0;
      end
      if (iINTERVAL_TICK && state != IDLE && oOVERRUN_CNT != 16'hFFFF)
        oOVERRUN_CNT <= oOVERRUN_CNT + 16'd1;
    end
  end

  assign oUCSTATS_REQ  = (state == REQ);
  assign oUCSTATS_DONE = (state == DONE);
  assign oBUSY         = (state != IDLE);

`ifdef UCSTATS_SCHED_TIMEOUT_EN
  logic [15:0] tcnt;

  // Counter is 0 on the first GNT cycle, so the grant lasts TIMEOUT_CYC cycles before giving up.
  assign tmo_hit = (state == GNT) && !rd_done && (tcnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tcnt           <= '0;
      oTIMEOUT_LINKS <= '0;
    end else begin
      tcnt <= (state == GNT) ? tcnt + 16'd1 : 16'd0;
      if (tmo_hit) oTIMEOUT_LINKS <= oTIMEOUT_LINKS | oLE_GNT;
    end
  end
`else
  // TIMEOUT_CYC is never 0 in a legal build, so this folds to constant 0.
  assign tmo_hit        = (TIMEOUT_CYC == 0);
  assign oTIMEOUT_LINKS = '0;
`endif

endmodule

// File: tb/tb_ucstats_invl_sched.sv
// Self-checking bench for ucstats_invl_sched: table-driven intervals with a grant scoreboard plus corner sequences.
module tb_ucstats_invl_sched;
  localparam int LINKS = 4;

  logic        iCLK = 1'b0, iRST_n = 1'b0, iINTERVAL_TICK = 1'b0, iUCSTATS_GNT = 1'b0;
  logic [3:0]  iLINK_EN = '0, iLE_RD_DONE = '0;
  logic        oUCSTATS_REQ, oUCSTATS_DONE, oBUSY;
  logic [3:0]  oLE_GNT, oCUR_LINK, oTIMEOUT_LINKS;
  logic [15:0] oOVERRUN_CNT;

  int n_tests = 0, n_fail = 0;
  int q[$];
  int last_link = 0;
  int ovr_exp = 0;

  always #5 iCLK = ~iCLK;

  ucstats_invl_sched #(.LINKS(LINKS), .TIMEOUT_CYC(8)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iINTERVAL_TICK(iINTERVAL_TICK), .iLINK_EN(iLINK_EN),
    .oUCSTATS_REQ(oUCSTATS_REQ), .iUCSTATS_GNT(iUCSTATS_GNT), .oUCSTATS_DONE(oUCSTATS_DONE),
    .oLE_GNT(oLE_GNT), .iLE_RD_DONE(iLE_RD_DONE), .oCUR_LINK(oCUR_LINK), .oBUSY(oBUSY),
    .oOVERRUN_CNT(oOVERRUN_CNT), .oTIMEOUT_LINKS(oTIMEOUT_LINKS)
  );

  typedef struct {
    logic [3:0] en;
    logic [3:0] en_mid;
    logic [3:0] stray;
    int         gd;
    int         dd;
    int         exp_cnt;
    int         exp_first;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_grant(input logic [3:0] en);
    iLINK_EN = en; iINTERVAL_TICK = 1'b1;
    @(negedge iCLK); iINTERVAL_TICK = 1'b0; iUCSTATS_GNT = 1'b1;
    @(negedge iCLK); iUCSTATS_GNT = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && oBUSY; i++) begin
      iLE_RD_DONE = oLE_GNT;
      @(negedge iCLK);
    end
    iLE_RD_DONE = '0;
    check({tag, "_idle"}, 32'(oBUSY), 32'd0);
  endtask

  task automatic pulse_reset();
    #2 iRST_n = 1'b0;
    @(negedge iCLK); iRST_n = 1'b1;
    last_link = 0; ovr_exp = 0;
  endtask

  // One full interval; grants are checked against a queue of expected links built from the mask.
  task automatic run_vec(input vec_t v, input string tag);
    int exp_l, hold, gap, ngr, first, dcnt, hi;
    logic [3:0] prev;
    logic [31:0] exp_oh;
    bit viol, fin;
    hi = 0;
    for (int i = 0; i < 4; i++) if (v.en[i]) begin q.push_back(i); hi = i; end
    iLINK_EN = v.en; iINTERVAL_TICK = 1'b1;
    @(negedge iCLK); iINTERVAL_TICK = 1'b0; iLINK_EN = v.en_mid;
    check({tag, "_req"}, 32'(oUCSTATS_REQ), 32'd1);
    check({tag, "_cur_in_req"}, 32'(oCUR_LINK), 32'(last_link));
    viol = 1'b0;
    for (int i = 0; i < v.gd; i++) begin
      @(negedge iCLK);
      if (!oUCSTATS_REQ || |oLE_GNT) viol = 1'b1;
    end
    iUCSTATS_GNT = 1'b1; @(negedge iCLK); iUCSTATS_GNT = 1'b0;
    hold = 0; gap = 0; ngr = 0; first = -1; dcnt = 0; prev = '0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      iLE_RD_DONE = '0;
      if ((oUCSTATS_REQ && |oLE_GNT) || !$onehot0(oLE_GNT) || oUCSTATS_REQ) viol = 1'b1;
      if (dcnt > 0) begin
        check({tag, "_busy_fall"}, 32'(oBUSY), 32'd0);
        check({tag, "_done_1cyc"}, 32'(oUCSTATS_DONE), 32'd0);
        fin = 1'b1;
      end else if (oLE_GNT != '0) begin
        if (prev == '0) begin
          exp_l  = (q.size() > 0) ? q.pop_front() : -1;
          exp_oh = (exp_l >= 0) ? (32'd1 << exp_l) : 32'hFFFF_FFFF;
          check({tag, "_gnt"}, 32'(oLE_GNT), exp_oh);
          check({tag, "_cur"}, 32'(oCUR_LINK), 32'(exp_l));
          if (ngr > 0) check({tag, "_gap"}, 32'(gap), 32'd1);
          if (ngr == 0) first = int'(oCUR_LINK);
          ngr++; hold = 0; gap = 0;
        end
        hold++;
        if (hold == v.dd) iLE_RD_DONE = oLE_GNT;
        else if (hold == 1) iLE_RD_DONE = v.stray & ~oLE_GNT;
      end else begin
        if (prev != '0) check({tag, "_len"}, 32'(hold), 32'(v.dd));
        if (oUCSTATS_DONE) begin
          check({tag, "_done_gap"}, 32'(gap), 32'd1);
          check({tag, "_cur_done"}, 32'(oCUR_LINK), 32'(hi));
          dcnt++;
        end else gap++;
      end
      prev = oLE_GNT;
      if (!fin) @(negedge iCLK);
    end
    iLE_RD_DONE = '0;
    check({tag, "_finished"}, 32'(fin), 32'd1);
    check({tag, "_ngrants"}, 32'(ngr), 32'(v.exp_cnt));
    check({tag, "_first"}, 32'(first), 32'(v.exp_first));
    check({tag, "_q_empty"}, 32'(q.size()), 32'd0);
    check({tag, "_exclusive"}, 32'(viol), 32'd0);
    check({tag, "_ovr"}, 32'(oOVERRUN_CNT), 32'(ovr_exp));
    q.delete();
    last_link = hi;
    if (!fin) drain({tag, "_recover"});
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{en: 4'b1111, en_mid: 4'b1111, stray: 4'b0000, gd: 1, dd: 5, exp_cnt: 4, exp_first: 0};
    vecs[1] = '{en: 4'b1010, en_mid: 4'b1010, stray: 4'b0000, gd: 0, dd: 2, exp_cnt: 2, exp_first: 1};
    vecs[2] = '{en: 4'b0001, en_mid: 4'b0001, stray: 4'b0000, gd: 3, dd: 1, exp_cnt: 1, exp_first: 0};
    vecs[3] = '{en: 4'b1000, en_mid: 4'b1000, stray: 4'b0000, gd: 0, dd: 3, exp_cnt: 1, exp_first: 3};
    vecs[4] = '{en: 4'b0101, en_mid: 4'b1010, stray: 4'b0000, gd: 2, dd: 4, exp_cnt: 2, exp_first: 0};
    vecs[5] = '{en: 4'b0001, en_mid: 4'b0001, stray: 4'b0100, gd: 0, dd: 6, exp_cnt: 1, exp_first: 0};

    #12;
    check("rst_req",  32'(oUCSTATS_REQ),   32'd0);
    check("rst_done", 32'(oUCSTATS_DONE),  32'd0);
    check("rst_gnt",  32'(oLE_GNT),        32'd0);
    check("rst_cur",  32'(oCUR_LINK),      32'd0);
    check("rst_busy", 32'(oBUSY),          32'd0);
    check("rst_ovr",  32'(oOVERRUN_CNT),   32'd0);
    check("rst_tmo",  32'(oTIMEOUT_LINKS), 32'd0);
    @(negedge iCLK); iRST_n = 1'b1;

    // Tick with empty mask and a stray uC grant are both ignored in IDLE.
    iLINK_EN = '0; iINTERVAL_TICK = 1'b1;
    @(negedge iCLK); iINTERVAL_TICK = 1'b0;
    check("zero_mask_req",  32'(oUCSTATS_REQ), 32'd0);
    check("zero_mask_busy", 32'(oBUSY),        32'd0);
    iUCSTATS_GNT = 1'b1;
    @(negedge iCLK); iUCSTATS_GNT = 1'b0;
    check("idle_gnt_busy", 32'(oBUSY),        32'd0);
    check("idle_gnt_le",   32'(oLE_GNT),      32'd0);
    check("zero_mask_ovr", 32'(oOVERRUN_CNT), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Three ticks while waiting for the uC grant.
    iLINK_EN = 4'b0001; iINTERVAL_TICK = 1'b1;
    @(negedge iCLK); iINTERVAL_TICK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iINTERVAL_TICK = 1'b1; @(negedge iCLK);
      iINTERVAL_TICK = 1'b0; @(negedge iCLK);
    end
    check("ovr3", 32'(oOVERRUN_CNT), 32'd3);
    iUCSTATS_GNT = 1'b1; @(negedge iCLK); iUCSTATS_GNT = 1'b0;
    check("ovr3_gnt", 32'(oLE_GNT), 32'b0001);
    iUCSTATS_GNT = 1'b1;
    @(negedge iCLK); iUCSTATS_GNT = 1'b0;
    check("gnt_in_gnt_ignored", 32'(oLE_GNT), 32'b0001);
    drain("ovr3");
    ovr_exp = 3; last_link = 0;
    run_vec(vecs[1], "post_ovr");

    // Reset while link 1 is granted: outputs drop without a clock edge.
    tick_grant(4'b0110);
    check("mid_gnt", 32'(oLE_GNT), 32'b0010);
    iINTERVAL_TICK = 1'b1; @(negedge iCLK); iINTERVAL_TICK = 1'b0;
    check("mid_ovr", 32'(oOVERRUN_CNT), 32'd4);
    #2 iRST_n = 1'b0;
    #1;
    check("arst_gnt",  32'(oLE_GNT),      32'd0);
    check("arst_cur",  32'(oCUR_LINK),    32'd0);
    check("arst_busy", 32'(oBUSY),        32'd0);
    check("arst_req",  32'(oUCSTATS_REQ), 32'd0);
    check("arst_ovr",  32'(oOVERRUN_CNT), 32'd0);
    @(negedge iCLK); iRST_n = 1'b1;
    last_link = 0; ovr_exp = 0;
    run_vec('{en: 4'b0011, en_mid: 4'b0011, stray: 4'b0000, gd: 0, dd: 2, exp_cnt: 2, exp_first: 0}, "after_rst");

    // Saturation: hold in REQ and tick every cycle past the counter limit.
    iLINK_EN = 4'b0001; iINTERVAL_TICK = 1'b1;
    @(negedge iCLK);
    for (int i = 0; i < 65540; i++) @(negedge iCLK);
    iINTERVAL_TICK = 1'b0;
    check("sat_ovr", 32'(oOVERRUN_CNT), 32'h0000_FFFF);
    check("sat_req", 32'(oUCSTATS_REQ), 32'd1);
    iUCSTATS_GNT = 1'b1; @(negedge iCLK); iUCSTATS_GNT = 1'b0;
    drain("sat");
    ovr_exp = 16'hFFFF; last_link = 0;
    run_vec(vecs[3], "post_sat");
    check("end_tmo", 32'(oTIMEOUT_LINKS), 32'd0);

`ifdef UCSTATS_SCHED_TIMEOUT_EN
    begin
      int h;
      pulse_reset();
      tick_grant(4'b1100);
      h = 0;
      while (oLE_GNT == 4'b0100 && h < 50) begin h++; @(negedge iCLK); end
      check("tmo_len",   32'(h), 32'd8);
      check("tmo_flag",  32'(oTIMEOUT_LINKS), 32'b0100);
      check("tmo_next",  32'(oLE_GNT), 32'd0);
      @(negedge iCLK);
      check("tmo_link3", 32'(oLE_GNT), 32'b1000);
      drain("tmo");
      check("tmo_sticky", 32'(oTIMEOUT_LINKS), 32'b0100);
      pulse_reset();
      tick_grant(4'b0100);
      for (int i = 0; i < 7; i++) @(negedge iCLK);
      check("tmo_edge_gnt", 32'(oLE_GNT), 32'b0100);
      iLE_RD_DONE = 4'b0100;
      @(negedge iCLK); iLE_RD_DONE = '0;
      check("tmo_edge_flag", 32'(oTIMEOUT_LINKS), 32'd0);
      drain("tmo_edge");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ucstats_invl_sched.md
Name: ucstats_invl_sched

Overview:
- Interval scheduler for the shared uC stats block.
- On each interval tick it requests the uC stats resource once, then grants each enabled link engine in ascending order.
- A link engine keeps its grant until it reports read-done; the scheduler then moves to the next enabled link.
- After the last link it pulses done to uC stats. Sits between the link engines and the uC stats request/grant/done interface.

Parameters:
- LINKS, 4, number of link engines (1..16).
- TIMEOUT_CYC, 1024, per-link grant timeout in cycles. Used only with the optional feature. Legal range 2..65535.

Ports:
- iCLK  input  1  clock
- iRST_n  input  1  asynchronous active-low reset
- iINTERVAL_TICK  input  1  single-cycle pulse that starts a stats interval
- iLINK_EN  input  LINKS  per-link participation mask
- oUCSTATS_REQ  output  1  request to uC stats
- iUCSTATS_GNT  input  1  grant from uC stats
- oUCSTATS_DONE  output  1  one-cycle pulse after the last link completes
- oLE_GNT  output  LINKS  one-hot grant to a link engine
- iLE_RD_DONE  input  LINKS  per-link read-complete pulse
- oCUR_LINK  output  4  binary index of the granted link
- oBUSY  output  1  high whenever the state is not IDLE
- oOVERRUN_CNT  output  16  count of dropped ticks, saturating
- oTIMEOUT_LINKS  output  LINKS  sticky per-link timeout flags

Behaviour:
- Clock iCLK; reset asynchronous, active-low, on iRST_n.
- Reset values: all outputs 0; state IDLE; latched mask 0; timeout counter 0.
- States: IDLE, REQ, GNT, NEXT, DONE.
- IDLE:
  - Tick with |iLINK_EN = 1: latch iLINK_EN into en_lat and go to REQ. oUCSTATS_REQ is high on the next cycle (latency 1).
  - Tick with iLINK_EN = 0: ignored; no request, no overrun count.
- REQ:
  - oUCSTATS_REQ stays high until iUCSTATS_GNT is sampled high.
  - On the grant cycle, select the lowest set bit of en_lat and go to GNT.
  - oUCSTATS_REQ falls and oLE_GNT[i] rises on the same next edge.
- GNT:
  - oLE_GNT[i] is held and oCUR_LINK = i.
  - On iLE_RD_DONE[i] go to NEXT; oLE_GNT is 0 in NEXT.
  - iLE_RD_DONE bits for non-granted links are ignored.
- NEXT (exactly one cycle):
  - If a set bit of en_lat exists above i, grant the lowest such bit and go to GNT.
  - Otherwise go to DONE.
  - The next grant or DONE appears 2 cycles after the done pulse.
- DONE: oUCSTATS_DONE high for exactly one cycle, then IDLE.
- Grant exclusivity: oLE_GNT is never multi-hot; oUCSTATS_REQ and oLE_GNT are never high together.
- Overrun: a tick in any state other than IDLE is dropped and oOVERRUN_CNT increments. It saturates at 16'hFFFF; it never wraps.
- Mask timing: iLINK_EN changes after latching have no effect until the next accepted tick.
- iUCSTATS_GNT high outside REQ is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The overrun count and timeout flags are cleared.
- oCUR_LINK holds its last value in IDLE, REQ and NEXT. It reads 0 after reset.

Optional Feature:
- Macro: UCSTATS_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to GNT and increments every cycle in GNT.
  - When the counter reaches TIMEOUT_CYC-1 without iLE_RD_DONE[i], set oTIMEOUT_LINKS[i] (sticky until reset) and go to NEXT as if done had occurred.
  - If done arrives in that same cycle, done wins and the flag is not set.
- Not defined:
  - GNT waits indefinitely.
  - oTIMEOUT_LINKS is tied to 0 and the counter is not built.

Test Plan:
- LINKS=4, iLINK_EN=4'b1111, tick; grant 3 cycles later; each link done 5 cycles after its grant -> oLE_GNT sequence 0001, 0010, 0100, 1000, each 5 cycles high with 1-cycle gaps; one oUCSTATS_DONE pulse; oBUSY falls after DONE.
- iLINK_EN=4'b1010 -> only links 1 and 3 granted; oCUR_LINK shows 1 then 3. iLINK_EN=0 with a tick -> no oUCSTATS_REQ and oOVERRUN_CNT stays 0.
- 3 ticks while busy -> oOVERRUN_CNT=3. Preload near saturation (or long run) -> holds at 16'hFFFF.
- iLE_RD_DONE[2] pulsed while link 0 is granted -> ignored; link 0 grant persists. Change iLINK_EN mid-interval -> sequence unchanged.
- Assert iRST_n low while in GNT on link 1 -> all outputs 0 asynchronously. After release, a new tick restarts from REQ.
- With UCSTATS_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, link 2 never sends done -> oLE_GNT[2] high for 8 cycles, oTIMEOUT_LINKS=4'b0100, link 3 granted next. A done on the 8th cycle -> flag stays 0.
